// File: rtl/secure_reg_access_ctrl.sv
// secure_reg_access_ctrl
// Round-robin arbitrated, privilege-checked access to one sensitive data
// register and a sticky lock bit. Each granted access takes three cycles:
// IDLE (grant + capture), ACCESS (rule check + storage update) and RESP
// (one-hot ack with the registered response).
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   req        per-requester request, held until ack
//   wr         per-requester 1=write, 0=read
//   addr       per-requester 0=data reg, 1=ctrl reg
//   priv       per-requester privilege flag
//   wdata      flattened write data, requester i at [i*DW +: DW]
//   ack        one-hot completion pulse (RESP cycle only)
//   rdata      read data, zero outside the ack cycle
//   err        access violation, zero outside the ack cycle
//   locked     sticky lock state
//   viol_cnt   saturating count of err responses
module secure_reg_access_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 32,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    wr,
  input  logic [NUM_REQ-1:0]    addr,
  input  logic [NUM_REQ-1:0]    priv,
  input  logic [NUM_REQ*DW-1:0] wdata,
  output logic [NUM_REQ-1:0]    ack,
  output logic [DW-1:0]         rdata,
  output logic                  err,
  output logic                  locked,
  output logic [CNT_W-1:0]      viol_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [IDX_W-1:0]     last_r, win_r;
  logic                 cap_wr_r, cap_addr_r, cap_priv_r;
  logic [DW-1:0]        cap_wdata_r;
  logic [DW-1:0]        data_r;
  logic                 locked_r;
  logic [CNT_W-1:0]     viol_cnt_r;
  logic [NUM_REQ-1:0]   ack_r;
  logic [DW-1:0]        rdata_r;
  logic                 err_r;

  logic                 grant_vld_s;
  logic [IDX_W-1:0]     grant_idx_s;
  logic [SUM_W-1:0]     sum_s;
  logic [IDX_W-1:0]     cand_s;
  logic                 acc_err_s;
  logic [DW-1:0]        acc_rdata_s;
  logic                 data_we_s;
  logic                 lock_set_s;

  // Round-robin pick: scan downwards so the candidate closest after last_r wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = last_r;
    sum_s       = '0;
    cand_s      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum_s = {1'b0, last_r} + SUM_W'(k);
      if (sum_s >= SUM_W'(NUM_REQ)) begin
        sum_s = sum_s - SUM_W'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IDX_W-1:0];
      if (req[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Access rule evaluation on the captured request.
  always_comb begin
    acc_err_s   = 1'b0;
    acc_rdata_s = '0;
    data_we_s   = 1'b0;
    lock_set_s  = 1'b0;
    if (cap_wr_r) begin
      if (!cap_addr_r) begin
        if (cap_priv_r && !locked_r) begin
          data_we_s = 1'b1;
        end else begin
          acc_err_s = 1'b1;
        end
      end else begin
        // Lock is one-way: once set, any ctrl write is a violation.
        if (!cap_priv_r || locked_r) begin
          acc_err_s = 1'b1;
        end else begin
          lock_set_s = cap_wdata_r[0];
        end
      end
    end else begin
      if (!cap_addr_r) begin
        if (cap_priv_r) begin
          acc_rdata_s = data_r;
        end else begin
          acc_err_s = 1'b1;
        end
      end else begin
        acc_rdata_s = {{(DW-1){1'b0}}, locked_r};
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_vld_s) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_nxt_s = ST_RESP;
      ST_RESP:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant capture and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r      <= IDX_W'(NUM_REQ - 1);
      win_r       <= '0;
      cap_wr_r    <= 1'b0;
      cap_addr_r  <= 1'b0;
      cap_priv_r  <= 1'b0;
      cap_wdata_r <= '0;
    end else if (state_r == ST_IDLE && grant_vld_s) begin
      win_r       <= grant_idx_s;
      cap_wr_r    <= wr[grant_idx_s];
      cap_addr_r  <= addr[grant_idx_s];
      cap_priv_r  <= priv[grant_idx_s];
      cap_wdata_r <= wdata[grant_idx_s*DW +: DW];
    end else if (state_r == ST_RESP) begin
      last_r <= win_r;
    end
  end

  // Protected storage: data register and sticky lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r   <= '0;
      locked_r <= 1'b0;
    end else if (state_r == ST_ACCESS) begin
      if (data_we_s) begin
        data_r <= cap_wdata_r;
      end
      if (lock_set_s) begin
        locked_r <= 1'b1;
      end
    end
  end

  // Registered response: only non-zero during RESP so nothing stale leaks.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r   <= '0;
      rdata_r <= '0;
      err_r   <= 1'b0;
    end else if (state_r == ST_ACCESS) begin
      ack_r   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_r;
      rdata_r <= acc_rdata_s;
      err_r   <= acc_err_s;
    end else begin
      ack_r   <= '0;
      rdata_r <= '0;
      err_r   <= 1'b0;
    end
  end

  // Saturating violation counter, bumped as each erroring response completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      viol_cnt_r <= '0;
    end else if (state_r == ST_RESP && err_r && viol_cnt_r != {CNT_W{1'b1}}) begin
      viol_cnt_r <= viol_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign ack      = ack_r;
  assign rdata    = rdata_r;
  assign err      = err_r;
  assign locked   = locked_r;
  assign viol_cnt = viol_cnt_r;

endmodule

// File: tb/tb_secure_reg_access_ctrl.sv
// Directed self-checking bench for secure_reg_access_ctrl (NUM_REQ=4, DW=32, CNT_W=8).
module tb_secure_reg_access_ctrl;

  logic         clk;
  logic         rst;
  logic [3:0]   req, wr, addr, priv;
  logic [127:0] wdata;
  logic [3:0]   ack;
  logic [31:0]  rdata;
  logic         err;
  logic         locked;
  logic [7:0]   viol_cnt;

  int total;
  int bad;

  secure_reg_access_ctrl #(.NUM_REQ(4), .DW(32), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wr       (wr),
    .addr     (addr),
    .priv     (priv),
    .wdata    (wdata),
    .ack      (ack),
    .rdata    (rdata),
    .err      (err),
    .locked   (locked),
    .viol_cnt (viol_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access by requester idx; returns response seen with ack, cycles to ack,
  // and rdata one cycle after ack (must be zero).
  task automatic do_access(input int idx, input logic w, input logic a, input logic p,
                           input logic [31:0] d, output logic [3:0] got_ack,
                           output logic [31:0] rd, output logic e, output int lat,
                           output logic [31:0] rd_after);
    wr[idx] = w;
    addr[idx] = a;
    priv[idx] = p;
    wdata[idx*32 +: 32] = d;
    req[idx] = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (ack == 4'b0000 && lat < 10);
    got_ack = ack;
    rd = rdata;
    e = err;
    req[idx] = 1'b0;
    tick();
    rd_after = rdata;
  endtask

  logic [3:0]  a_s;
  logic [31:0] rd_s, rda_s;
  logic        e_s;
  int          lat_s;
  logic [3:0]  seen_ack [5];
  int          seen_cyc [5];
  int          n_seen;
  int          no_ack;

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    req = 4'b0000;
    wr = 4'b0000;
    addr = 4'b0000;
    priv = 4'b0000;
    wdata = 128'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check_val("reset_ack", 64'(ack), 64'h0);
    check_val("reset_rdata", 64'(rdata), 64'h0);
    check_val("reset_err", 64'(err), 64'h0);
    check_val("reset_locked", 64'(locked), 64'h0);
    check_val("reset_viol", 64'(viol_cnt), 64'h0);

    // Privileged write then read back
    do_access(0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, a_s, rd_s, e_s, lat_s, rda_s);
    check_val("wr0_ack", 64'(a_s), 64'h1);
    check_val("wr0_lat", 64'(lat_s), 64'd2);
    check_val("wr0_err", 64'(e_s), 64'h0);
    check_val("wr0_rdata", 64'(rd_s), 64'h0);
    do_access(0, 1'b0, 1'b0, 1'b1, 32'h0, a_s, rd_s, e_s, lat_s, rda_s);
    check_val("rd0_rdata", 64'(rd_s), 64'hDEADBEEF);
    check_val("rd0_err", 64'(e_s), 64'h0);
    check_val("rd0_rdata_after", 64'(rda_s), 64'h0);
    check_val("rd0_viol", 64'(viol_cnt), 64'd0);

    // Unprivileged read and write
    do_access(1, 1'b0, 1'b0, 1'b0, 32'h0, a_s, rd_s, e_s, lat_s, rda_s);
    check_val("rd1_ack", 64'(a_s), 64'h2);
    check_val("rd1_rdata", 64'(rd_s), 64'h0);
    check_val("rd1_err", 64'(e_s), 64'h1);
    check_val("rd1_viol", 64'(viol_cnt), 64'd1);
    do_access(1, 1'b1, 1'b0, 1'b0, 32'h12345678, a_s, rd_s, e_s, lat_s, rda_s);
    check_val("wr1_err", 64'(e_s), 64'h1);
    check_val("wr1_viol", 64'(viol_cnt), 64'd2);
    do_access(0, 1'b0, 1'b0, 1'b1, 32'h0, a_s, rd_s, e_s, lat_s, rda_s);
    check_val("wr1_data_kept", 64'(rd_s), 64'hDEADBEEF);

    // Lock and post-lock behaviour
    do_access(0, 1'b1, 1'b1, 1'b1, 32'h1, a_s, rd_s, e_s, lat_s, rda_s);
    check_val("lock_err", 64'(e_s), 64'h0);
    check_val("lock_set", 64'(locked), 64'h1);
    do_access(0, 1'b1, 1'b0, 1'b1, 32'h0BADF00D, a_s, rd_s, e_s, lat_s, rda_s);
    check_val("locked_wr_err", 64'(e_s), 64'h1);
    do_access(0, 1'b0, 1'b0, 1'b1, 32'h0, a_s, rd_s, e_s, lat_s, rda_s);
    check_val("locked_data_kept", 64'(rd_s), 64'hDEADBEEF);
    do_access(0, 1'b1, 1'b1, 1'b1, 32'h0, a_s, rd_s, e_s, lat_s, rda_s);
    check_val("unlock_err", 64'(e_s), 64'h1);
    check_val("unlock_locked", 64'(locked), 64'h1);
    do_access(2, 1'b0, 1'b1, 1'b0, 32'h0, a_s, rd_s, e_s, lat_s, rda_s);
    check_val("ctrl_rd_ack", 64'(a_s), 64'h4);
    check_val("ctrl_rd_rdata", 64'(rd_s), 64'h1);
    check_val("ctrl_rd_err", 64'(e_s), 64'h0);
    check_val("lock_viol", 64'(viol_cnt), 64'd4);

    // Round-robin with all requests held from reset
    rst = 1'b1;
    tick();
    tick();
    req = 4'b1111;
    wr = 4'b0000;
    addr = 4'b1111;
    priv = 4'b1111;
    rst = 1'b0;
    n_seen = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (ack != 4'b0000 && n_seen < 5) begin
        seen_ack[n_seen] = ack;
        seen_cyc[n_seen] = cyc;
        n_seen++;
      end
    end
    req = 4'b0000;
    tick();
    tick();
    tick();
    check_val("rr_count", 64'(n_seen), 64'd5);
    check_val("rr_first_cyc", 64'(seen_cyc[0]), 64'd2);
    check_val("rr_ack0", 64'(seen_ack[0]), 64'h1);
    check_val("rr_ack1", 64'(seen_ack[1]), 64'h2);
    check_val("rr_ack2", 64'(seen_ack[2]), 64'h4);
    check_val("rr_ack3", 64'(seen_ack[3]), 64'h8);
    check_val("rr_ack4", 64'(seen_ack[4]), 64'h1);
    for (int i = 1; i < 5; i++) begin
      check_val($sformatf("rr_gap%0d", i), 64'(seen_cyc[i] - seen_cyc[i-1]), 64'd3);
    end
    check_val("rr_viol", 64'(viol_cnt), 64'd0);

    // Put data and lock into a non-reset state, then saturate the counter
    do_access(3, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D, a_s, rd_s, e_s, lat_s, rda_s);
    check_val("pre_wr_err", 64'(e_s), 64'h0);
    do_access(3, 1'b1, 1'b1, 1'b1, 32'h1, a_s, rd_s, e_s, lat_s, rda_s);
    check_val("pre_lock", 64'(locked), 64'h1);
    for (int i = 0; i < 255; i++) begin
      do_access(1, 1'b0, 1'b0, 1'b0, 32'h0, a_s, rd_s, e_s, lat_s, rda_s);
    end
    check_val("sat_255", 64'(viol_cnt), 64'd255);
    for (int i = 0; i < 5; i++) begin
      do_access(1, 1'b0, 1'b0, 1'b0, 32'h0, a_s, rd_s, e_s, lat_s, rda_s);
    end
    check_val("sat_260", 64'(viol_cnt), 64'd255);
    check_val("sat_last_err", 64'(e_s), 64'h1);

    // Reset during ACCESS of a privileged write aborts it
    wr[2] = 1'b1;
    addr[2] = 1'b0;
    priv[2] = 1'b1;
    wdata[64 +: 32] = 32'h55AA55AA;
    req[2] = 1'b1;
    tick();          // IDLE grants, now in ACCESS
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req[2] = 1'b0;
    no_ack = 0;
    for (int i = 0; i < 4; i++) begin
      if (ack != 4'b0000) no_ack++;
      tick();
    end
    check_val("abort_no_ack", 64'(no_ack), 64'd0);
    check_val("abort_locked", 64'(locked), 64'h0);
    check_val("abort_viol", 64'(viol_cnt), 64'd0);

    // Next request after reset goes to r0; data register reads back as zero
    wr = 4'b0000;
    addr = 4'b0000;
    priv = 4'b1111;
    req = 4'b1001;
    lat_s = 0;
    do begin
      tick();
      lat_s++;
    end while (ack == 4'b0000 && lat_s < 10);
    check_val("post_rst_ack", 64'(ack), 64'h1);
    check_val("post_rst_data", 64'(rdata), 64'h0);
    req = 4'b0000;
    tick();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/secure_reg_access_ctrl.md
Name: secure_reg_access_ctrl

Overview:
- Arbitrated, privilege-checked access controller for one sensitive data register plus a sticky lock bit.
- Shares the register between NUM_REQ requesters using round-robin arbitration.
- Blocks unprivileged reads and writes, and blocks all data writes once the register is locked.
- Sits between bus-side requesters and the sensitive storage, so that storage is never written or exposed directly.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DW, 32, data register width
CNT_W, 8, width of the saturating violation counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req  in  NUM_REQ  per-requester request, held high until ack
wr  in  NUM_REQ  per-requester 1=write, 0=read
addr  in  NUM_REQ  per-requester select: 0=data reg, 1=ctrl reg
priv  in  NUM_REQ  per-requester privilege flag
wdata  in  NUM_REQ*DW  flattened write data; requester i uses bits [i*DW +: DW]
ack  out  NUM_REQ  one-hot, one-cycle completion pulse
rdata  out  DW  read data, valid only while ack is high, else 0
err  out  1  access-violation flag, valid only while ack is high, else 0
locked  out  1  current lock state
viol_cnt  out  CNT_W  saturating count of err responses

Behaviour:
- Reset state (applied at the clk edge with rst=1):
  - FSM goes to IDLE.
  - Data reg=0, locked=0, viol_cnt=0.
  - ack=0, rdata=0, err=0.
  - RR pointer last=NUM_REQ-1, so requester 0 has first priority.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req bit is high, choose the winner w = first set bit scanning from last+1, wrapping modulo NUM_REQ.
  - Capture wr[w], addr[w], priv[w] and wdata slice w into internal registers, then go to ACCESS.
  - If no req bit is high, stay in IDLE.
- ACCESS (one cycle): evaluate the captured access against the rules below, update storage, register the response, then go to RESP.
  - Write, data reg:
    - If priv=1 and locked=0: data reg <= wdata, err=0.
    - Otherwise: no update, err=1.
  - Write, ctrl reg:
    - priv=0: err=1.
    - priv=1 and locked=1: err=1. Lock cannot be cleared; the write is ignored.
    - priv=1, locked=0, wdata[0]=1: locked <= 1, err=0.
    - priv=1, locked=0, wdata[0]=0: no-op, err=0.
  - Read, data reg:
    - priv=1: rdata = data reg, err=0.
    - priv=0: rdata = 0, err=1.
  - Read, ctrl reg: rdata = {zeros, locked}, err=0, for any privilege.
  - Writes always return rdata=0.
- RESP (one cycle):
  - ack[w]=1; rdata and err are driven with the registered response.
  - last <= w.
  - If err=1, viol_cnt increments, saturating at all-ones.
  - Next state is IDLE.
- Latency:
  - req seen in IDLE at cycle T gives ACCESS at T+1 and ack at T+2.
  - Back-to-back grants are spaced every 3 cycles.
  - A requester deasserts req in the cycle after ack; because the next IDLE cycle samples req after that, no double service occurs.
- Inputs are captured at grant:
  - Changes to wr, addr, priv or wdata after the grant are ignored.
  - A req dropped after the grant still completes and receives its ack.
- Outside RESP, ack=0, rdata=0 and err=0, so no stale data leaks.
- locked is sticky; only rst clears it.
- Simultaneous requests are served in strict round-robin order. No requester can be starved; the worst-case wait is NUM_REQ grants.
- rst during ACCESS or RESP aborts the access: no ack and no counter increment.
  - If storage was already written in ACCESS, the same-edge rst clears it anyway.

Test Plan:
- Priv write then read: r0 writes data=0xDEADBEEF with priv=1 (ack at T+2, err=0), then reads it back. -> rdata=0xDEADBEEF, err=0, viol_cnt=0.
- Unprivileged access: r1 reads the data reg with priv=0 -> rdata=0, err=1, viol_cnt=1. r1 then writes 0x12345678 with priv=0 -> err=1, data unchanged, viol_cnt=2.
- Lock:
  - r0 writes ctrl=1 with priv=1 -> locked=1.
  - r0 writes data=0x0BADF00D with priv=1 -> err=1, data still 0xDEADBEEF.
  - r0 writes ctrl=0 -> err=1, locked stays 1.
  - r2 reads ctrl with priv=0 -> rdata=1, err=0.
- Round-robin: all 4 req held continuously from reset -> acks in order r0,r1,r2,r3,r0, spaced 3 cycles apart, each ack one-hot.
- Saturation and reset: 260 unprivileged reads -> viol_cnt stops at 255. Then assert rst during ACCESS of a priv write -> no ack; data=0, locked=0, viol_cnt=0; the next request is granted to r0.
